vpu_line_scanout: RTL and testbench
===================================

// Module: vpu_line_scanout
// PURPOSE
//  Consumer of the double-banked sprite line buffer. During line y the sprite stage writes bank y[0];
//  this block reads the opposite bank (line y-1), substitutes the backdrop for transparent pixels,
//  and streams RGB pixels to the display interface over a valid/ready link. Each slot is cleared to
//  0 after it is read, so the bank is blank when the sprite stage reuses it on the next line.
// PARAMETERS
//  LINE_W        default 240   visible pixels per line (x = 0..LINE_W-1)
//  SCREEN_H      default 160   visible lines; displayed line index 0..SCREEN_H-1
//  START_CYCLE   default 20    line_cycle value that starts scanout of a line
//  FIFO_DEPTH    default 4     output pixel FIFO entries (power of 2, >=2)
//  ADDR_W        default 9     line buffer address width (LINEBUFF_ADDR_W)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous reset, active low
//  line_cycle   in   11      cycle counter within the current line
//  y            in   9       current render line (sprite stage writes bank y[0])
//  bg_color     in   24      backdrop RGB used where pixel alpha == 0
//  line_wea     out  1       line buffer port A write enable
//  line_banka   out  1       port A bank select, always ~y[0]
//  line_addra   out  ADDR_W  port A address
//  line_dina    out  32      port A write data, always 32'h0
//  line_douta   in   32      port A read data, 1-cycle latency, {A,R,G,B}
//  pix_valid    out  1       output pixel valid
//  pix_ready    in   1       display accepts pixel
//  pix_x        out  9       x of output pixel
//  pix_y        out  8       displayed line (y-1)
//  pix_rgb      out  24      pixel colour
//  line_overrun out  1       1-cycle pulse: new line started before previous drained
// BEHAVIOUR
//  Reset: every output is 0. FSM goes to IDLE, FIFO empties, x = 0.
//  States:
//   - IDLE -> READ when line_cycle==START_CYCLE and 1<=y<=SCREEN_H. Latch dy = y-1, x = 0.
//   - READ: drive addr=x, wea=0. Advance to CLEAR only when fifo_count < FIFO_DEPTH. Otherwise stay
//     in READ (stall); re-reading the same address is harmless.
//   - CLEAR: drive addr=x, wea=1, dina=0. Push {x, dy, colour(line_douta)} to the FIFO.
//     Then x==LINE_W-1 -> DRAIN, else x++ and -> READ.
//   - DRAIN -> IDLE when the FIFO is empty.
//  Throughput: max 1 pixel per 2 cycles. Read data is sampled in the CLEAR cycle, which is the cycle
//   after the READ that issued the address.
//  Colour: alpha = douta[31:24]. rgb = (alpha==0) ? bg_color : douta[23:0]. No blending here.
//  FIFO:
//   - First-word-fall-through. pix_valid = !empty. Head pops when pix_valid && pix_ready.
//   - Push and pop in the same cycle keep the count unchanged.
//   - The CLEAR push is only entered with count<FIFO_DEPTH, so the FIFO never overflows.
//   - pix_* hold stable while valid && !ready.
//  Line start while not IDLE (START_CYCLE with y in range):
//   - pulse line_overrun for 1 cycle, flush the FIFO, restart READ at x=0 for the new line.
//   - Unread slots of the old bank are not cleared.
//  The y range check excludes y==0 and blank lines. line_banka tracks ~y[0] combinationally.
//  Reset asserted mid-line: immediate return to IDLE; partially cleared bank is left as is.
// TESTING
//  1. Bank ~y[0] preloaded with addr*0x01010101|0xFF000000, y=5, ready=1 -> 240 pixels, pix_y=4,
//     pix_x=0..239, rgb=addr*0x010101, one pixel every 2 cycles, all slots read 0 afterwards.
//  2. Slot 7 = 0x00123456, bg_color=0xABCDEF -> pixel x=7 rgb=0xABCDEF.
//  3. pix_ready=0 for 20 cycles mid-line -> exactly FIFO_DEPTH pixels buffered, READ stalls,
//     no lost or duplicated x, sequence resumes in order.
//  4. y=0 and y=SCREEN_H+1 at START_CYCLE -> stays IDLE, wea never asserted, no pixels.
//  5. ready=0 throughout, second START_CYCLE arrives -> line_overrun pulses once, FIFO flushed,
//     next pixel is x=0 of the new line.
//  6. rst_n low mid-line -> all outputs 0 asynchronously; after release no pixels until next START_CYCLE.

Source files
------------

// File: rtl/vpu_line_scanout_if.sv
// vpu_line_scanout_if: line buffer port A plus the valid/ready pixel stream of the scanout block.
interface vpu_line_scanout_if #(parameter int ADDR_W = 9);
   logic              line_wea;
   logic              line_banka;
   logic [ADDR_W-1:0] line_addra;
   logic [31:0]       line_dina;
   logic [31:0]       line_douta;
   logic              pix_valid;
   logic              pix_ready;
   logic [8:0]        pix_x;
   logic [7:0]        pix_y;
   logic [23:0]       pix_rgb;
   modport master (
      output line_wea, line_banka, line_addra, line_dina, pix_valid, pix_x, pix_y, pix_rgb,
      input  line_douta, pix_ready
   );
   modport slave (
      input  line_wea, line_banka, line_addra, line_dina, pix_valid, pix_x, pix_y, pix_rgb,
      output line_douta, pix_ready
   );
endinterface

// File: rtl/vpu_line_scanout.sv
// vpu_line_scanout: reads the previous line's sprite bank, clears each slot behind the read,
// substitutes the backdrop for transparent pixels and streams RGB through a small FWFT FIFO.
module vpu_line_scanout #(
   parameter int LINE_W      = 240,
   parameter int SCREEN_H    = 160,
   parameter int START_CYCLE = 20,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_W      = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [10:0]               line_cycle,
   input  logic [8:0]                y,
   input  logic [23:0]               bg_color,
   vpu_line_scanout_if.master        bus,
   output logic                      line_overrun
);
   localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, CLEAR = 2'd2, DRAIN = 2'd3;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW:0] DEPTH = FIFO_DEPTH[PW:0];

   logic [1:0]    state;
   logic [8:0]    x;
   logic [7:0]    dy;
   logic [40:0]   mem [FIFO_DEPTH];
   logic [40:0]   head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          start, last, full, push, pop;
   logic [23:0]   rgb;

   assign start = line_cycle == 11'(START_CYCLE) && y != 9'd0 && y <= 9'(SCREEN_H);
   assign last  = x == 9'(LINE_W - 1);
   assign full  = count == DEPTH;
   assign push  = state == CLEAR;
   assign pop   = bus.pix_valid && bus.pix_ready;
   assign rgb   = bus.line_douta[31:24] == 8'd0 ? bg_color : bus.line_douta[23:0];
   assign head  = mem[rd_ptr];

   assign bus.line_wea   = state == CLEAR;
   // Gated by rst_n so the bank select also reads 0 while reset is held.
   assign bus.line_banka = rst_n & ~y[0];
   assign bus.line_addra = (state == READ || state == CLEAR) ? ADDR_W'(x) : '0;
   assign bus.line_dina  = '0;
   assign bus.pix_valid  = count != '0;
   assign bus.pix_x      = bus.pix_valid ? head[40:32] : '0;
   assign bus.pix_y      = bus.pix_valid ? head[31:24] : '0;
   assign bus.pix_rgb    = bus.pix_valid ? head[23:0]  : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         x            <= '0;
         dy           <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         line_overrun <= 1'b0;
      end else begin
         line_overrun <= start && state != IDLE;
         state  <= start ? READ :
                   (state == READ && !full) ? CLEAR :
                   (state == CLEAR) ? (last ? DRAIN : READ) :
                   (state == DRAIN && count == '0) ? IDLE : state;
         x      <= start ? '0 : (state == CLEAR && !last) ? x + 9'd1 : x;
         dy     <= start ? 8'(y - 9'd1) : dy;
         // A new line start flushes the FIFO, discarding any same-cycle push or pop.
         wr_ptr <= start ? '0 : wr_ptr + PW'(push);
         rd_ptr <= start ? '0 : rd_ptr + PW'(pop);
         count  <= start ? '0 : count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !start) mem[wr_ptr] <= {x, dy, rgb};
   end
endmodule

// File: tb/tb_vpu_line_scanout.sv
// tb_vpu_line_scanout: directed line scenarios with randomized bank contents and ready,
// checked against an expected pixel queue built from the preloaded bank contents.
module tb_vpu_line_scanout;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [23:0] rgb;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] line_cycle = '0;
   logic [8:0]  y = '0;
   logic [23:0] bg_color = '0;
   logic        line_overrun;

   vpu_line_scanout_if bus ();

   vpu_line_scanout dut (
      .clk(clk), .rst_n(rst_n), .line_cycle(line_cycle), .y(y),
      .bg_color(bg_color), .bus(bus), .line_overrun(line_overrun)
   );

   always #5 clk = ~clk;

   logic [31:0] lb   [2][512];
   logic [31:0] gold [2][240];
   logic        pre_we = 1'b0;
   logic        pre_bank = 1'b0;
   logic [8:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   always @(posedge clk) begin
      bus.line_douta <= lb[bus.line_banka][bus.line_addra];
      if (pre_we) lb[pre_bank][pre_addr] <= pre_data;
      else if (bus.line_wea) lb[bus.line_banka][bus.line_addra] <= bus.line_dina;
   end

   int          checks = 0, passed = 0;
   int          cyc = 0, last_acc = 0, first_acc = 0, pix_cnt = 0, wea_cnt = 0, ovr_cnt = 0;
   int          s0, nz;
   bit          rate_chk = 0;
   logic [8:0]  first_x;
   logic [23:0] got7;
   pix_t        exq[$];
   pix_t        p, e;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      #1;
      if (bus.pix_valid && bus.pix_ready) begin
         p = {bus.pix_x, bus.pix_y, bus.pix_rgb};
         check("pix_expected", 64'(exq.size() != 0), 64'd1);
         if (exq.size() != 0) begin
            e = exq.pop_front();
            check("pix_x", 64'(p.x), 64'(e.x));
            check("pix_y", 64'(p.y), 64'(e.y));
            check("pix_rgb", 64'(p.rgb), 64'(e.rgb));
         end
         if (rate_chk && pix_cnt != 0) check("pix_rate", 64'(cyc - last_acc), 64'd2);
         if (pix_cnt == 0) begin
            first_acc = cyc;
            first_x   = p.x;
         end
         if (p.x == 9'd7) got7 = p.rgb;
         last_acc = cyc;
         pix_cnt++;
      end
      wea_cnt += int'(bus.line_wea);
      ovr_cnt += int'(line_overrun);
      @(negedge clk);
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input bit bank, input int a, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_bank = bank;
      pre_addr = 9'(a);
      pre_data = d;
      gold[bank][a] = d;
      tick();
      pre_we = 1'b0;
   endtask

   // mode 0: opaque ramp pattern; mode 1: random words, about a quarter transparent
   task automatic preload(input bit bank, input bit mode);
      logic [31:0] d;
      for (int a = 0; a < 240; a++) begin
         d = $urandom;
         if ($urandom_range(3) == 0) d[31:24] = 8'h00;
         wr(bank, a, mode ? d : (32'(a) * 32'h0101_0101) | 32'hFF00_0000);
      end
   endtask

   task automatic build(input bit bank, input logic [7:0] dy);
      for (int a = 0; a < 240; a++)
         exq.push_back({9'(a), dy, gold[bank][a][31:24] == 8'h00 ? bg_color : gold[bank][a][23:0]});
   endtask

   task automatic clr_counts();
      pix_cnt = 0;
      wea_cnt = 0;
      ovr_cnt = 0;
   endtask

   task automatic start_line(input logic [8:0] yy);
      y          = yy;
      line_cycle = 11'd20;
      s0         = cyc;
      tick();
      line_cycle = 11'd0;
   endtask

   task automatic run_line(input bit rnd);
      for (int i = 0; i < 3000 && exq.size() != 0; i++) begin
         if (rnd) bus.pix_ready = 1'($urandom_range(1));
         tick();
      end
      check("line_drained", 64'(exq.size()), 64'd0);
      bus.pix_ready = 1'b1;
      ticks(4);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wea"}, 64'(bus.line_wea), 64'd0);
      check({tag, "_banka"}, 64'(bus.line_banka), 64'd0);
      check({tag, "_addra"}, 64'(bus.line_addra), 64'd0);
      check({tag, "_dina"}, 64'(bus.line_dina), 64'd0);
      check({tag, "_valid"}, 64'(bus.pix_valid), 64'd0);
      check({tag, "_x"}, 64'(bus.pix_x), 64'd0);
      check({tag, "_y"}, 64'(bus.pix_y), 64'd0);
      check({tag, "_rgb"}, 64'(bus.pix_rgb), 64'd0);
      check({tag, "_overrun"}, 64'(line_overrun), 64'd0);
   endtask

   initial begin
      bus.pix_ready = 1'b0;
      y = 9'd1;
      @(negedge clk);
      ticks(3);
      check_zero("reset");
      rst_n = 1'b1;
      ticks(2);

      // ramp line, full-rate scanout, bank cleared afterwards
      preload(0, 0);
      bg_color = 24'h000000;
      build(0, 8'd4);
      clr_counts();
      rate_chk = 1;
      bus.pix_ready = 1'b1;
      start_line(9'd5);
      run_line(0);
      rate_chk = 0;
      check("t1_pixels", 64'(pix_cnt), 64'd240);
      check("t1_first_latency", 64'(first_acc - s0), 64'd3);
      check("t1_writes", 64'(wea_cnt), 64'd240);
      check("t1_no_overrun", 64'(ovr_cnt), 64'd0);
      nz = 0;
      for (int a = 0; a < 240; a++) if (lb[0][a] !== 32'h0) nz++;
      check("t1_bank_cleared", 64'(nz), 64'd0);

      // transparent slot takes the backdrop; random ready
      preload(1, 1);
      wr(1, 7, 32'h0012_3456);
      bg_color = 24'hABCDEF;
      build(1, 8'd5);
      clr_counts();
      got7 = '0;
      start_line(9'd6);
      run_line(1);
      check("t2_pixels", 64'(pix_cnt), 64'd240);
      check("t2_slot7_bg", 64'(got7), 64'hABCDEF);

      // 20-cycle ready stall mid-line
      preload(0, 1);
      bg_color = 24'h13579B;
      build(0, 8'd6);
      clr_counts();
      bus.pix_ready = 1'b1;
      start_line(9'd7);
      ticks(30);
      bus.pix_ready = 1'b0;
      ticks(20);
      #1;
      check("t3_buffered", 64'(wea_cnt - pix_cnt), 64'(DEPTH));
      check("t3_stalled_wea", 64'(bus.line_wea), 64'd0);
      check("t3_valid_held", 64'(bus.pix_valid), 64'd1);
      bus.pix_ready = 1'b1;
      run_line(0);
      check("t3_pixels", 64'(pix_cnt), 64'd240);

      // out-of-range lines never start
      clr_counts();
      start_line(9'd0);
      ticks(40);
      start_line(9'd161);
      ticks(40);
      check("t4_no_writes", 64'(wea_cnt), 64'd0);
      check("t4_no_pixels", 64'(pix_cnt), 64'd0);

      // overrun: blocked line restarted by the next line start
      preload(0, 1);
      preload(1, 1);
      bg_color = 24'($urandom);
      bus.pix_ready = 1'b0;
      build(1, 8'd7);
      clr_counts();
      start_line(9'd8);
      ticks(30);
      check("t5_no_early_overrun", 64'(ovr_cnt), 64'd0);
      exq.delete();
      build(0, 8'd8);
      clr_counts();
      start_line(9'd9);
      bus.pix_ready = 1'b1;
      ticks(4);
      check("t5_overrun_once", 64'(ovr_cnt), 64'd1);
      run_line(0);
      check("t5_first_x", 64'(first_x), 64'd0);
      check("t5_pixels", 64'(pix_cnt), 64'd240);
      check("t5_overrun_total", 64'(ovr_cnt), 64'd1);

      // asynchronous reset mid-line
      preload(1, 1);
      build(1, 8'd9);
      start_line(9'd10);
      ticks(40);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      exq.delete();
      ticks(2);
      rst_n = 1'b1;
      clr_counts();
      ticks(50);
      check("t6_no_pixels", 64'(pix_cnt), 64'd0);
      check("t6_no_writes", 64'(wea_cnt), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
